// File: rtl/mem_buf_server_pkg.sv
// Shared request-word layout and FSM encoding for the buffer server and its reader peer.
package mem_buf_server_pkg;

  // Request word field layout, common with mem_buf_reader
  localparam int unsigned MEM_BEAT_ADDR_WIDTH = 16;
  localparam int unsigned MEM_BUF_IDX_WIDTH   = 2;
  localparam int unsigned MEM_LENGTH_POS      = 32;
  localparam int unsigned MEM_ADDR_POS        = 0;
  localparam int unsigned MEM_BUF_IDX_POS     = MEM_BEAT_ADDR_WIDTH;
  localparam int unsigned MEM_REQ_WIDTH       = MEM_LENGTH_POS + MEM_BEAT_ADDR_WIDTH;

  // FSM encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_READ = 1'b1;

  // Decoded request payload
  typedef struct packed {
    logic [MEM_BUF_IDX_WIDTH-1:0]   buf_idx;
    logic [MEM_BEAT_ADDR_WIDTH-1:0] addr;
    logic [MEM_BEAT_ADDR_WIDTH-1:0] length;
  } mem_req_t;

  // A zero-length request is served as a single beat
  function automatic logic [MEM_BEAT_ADDR_WIDTH-1:0] eff_length(
    input logic [MEM_BEAT_ADDR_WIDTH-1:0] len
  );
    return (len == '0) ? MEM_BEAT_ADDR_WIDTH'(1) : len;
  endfunction

endpackage

// File: rtl/mem_buf_server_ram.sv
// Banked buffer RAM: simple dual-port, read-first, one-cycle registered read.
module mem_buf_server_ram #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 15
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Write port; storage array carries no reset
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read; non-blocking update makes a same-address write return old data
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/mem_buf_server.sv
// Memory-side responder: accepts burst read requests, reads the banked buffer RAM
// and streams the beats back in order with tlast on the final beat of each burst.
module mem_buf_server
  import mem_buf_server_pkg::*;
#(
  parameter int unsigned AXI4S_DATA_WIDTH = 64,
  parameter int unsigned RAM_ADDR_WIDTH   = 13,
  parameter int unsigned OUT_FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [AXI4S_DATA_WIDTH-1:0]   req_axis_tdata,
  input  logic                          req_axis_tvalid,
  output logic                          req_axis_tready,
  output logic [AXI4S_DATA_WIDTH-1:0]   rsp_axis_tdata,
  output logic                          rsp_axis_tlast,
  output logic                          rsp_axis_tvalid,
  input  logic                          rsp_axis_tready,
  input  logic                          wr_en,
  input  logic [MEM_BUF_IDX_WIDTH-1:0]  wr_buf_idx,
  input  logic [RAM_ADDR_WIDTH-1:0]     wr_addr,
  input  logic [AXI4S_DATA_WIDTH-1:0]   wr_data,
  output logic                          busy_out,
  output logic [1:0]                    err_out,
  output logic [15:0]                   beat_count_out
);

  localparam int unsigned PTR_W  = $clog2(OUT_FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned USED_W = CNT_W + 1;
  localparam int unsigned RAM_AW = MEM_BUF_IDX_WIDTH + RAM_ADDR_WIDTH;

  // Control state
  logic [0:0]                     r_state;
  logic [0:0]                     w_state_nxt;
  logic                           r_req_ready;
  logic [MEM_BUF_IDX_WIDTH-1:0]   r_buf;
  logic [RAM_ADDR_WIDTH-1:0]      r_addr;
  logic [MEM_BEAT_ADDR_WIDTH-1:0] r_remaining;
  logic                           r_inflight;
  logic                           r_inflight_last;
  logic [1:0]                     r_err;
  logic [15:0]                    r_beat_cnt;

  // Output FIFO
  logic [AXI4S_DATA_WIDTH-1:0]    r_fifo_data [OUT_FIFO_DEPTH];
  logic                           r_fifo_last [OUT_FIFO_DEPTH];
  logic [PTR_W-1:0]               r_wr_ptr;
  logic [PTR_W-1:0]               r_rd_ptr;
  logic [CNT_W-1:0]               r_count;

  mem_req_t                       w_req;
  logic                           w_req_hs;
  logic                           w_addr_hi_err;
  logic                           w_issue;
  logic                           w_last_issue;
  logic [USED_W-1:0]              w_used;
  logic                           w_has_credit;
  logic                           w_push;
  logic                           w_pop;
  logic                           w_fifo_nonempty;
  logic [AXI4S_DATA_WIDTH-1:0]    w_ram_rd_data;
  logic                           w_unused;

  // Slice the request word into its fields; remaining bits are don't-care
  always_comb begin
    w_req         = '0;
    w_req.buf_idx = req_axis_tdata[MEM_BUF_IDX_POS +: MEM_BUF_IDX_WIDTH];
    w_req.addr    = req_axis_tdata[MEM_ADDR_POS +: MEM_BEAT_ADDR_WIDTH];
    w_req.length  = req_axis_tdata[MEM_LENGTH_POS +: MEM_BEAT_ADDR_WIDTH];
  end

  assign w_unused = ^{req_axis_tdata[AXI4S_DATA_WIDTH-1:MEM_REQ_WIDTH],
                      req_axis_tdata[MEM_LENGTH_POS-1:MEM_BUF_IDX_POS+MEM_BUF_IDX_WIDTH]};

  assign w_req_hs      = r_req_ready & req_axis_tvalid;
  assign w_addr_hi_err = |w_req.addr[MEM_BEAT_ADDR_WIDTH-1:RAM_ADDR_WIDTH];
  assign w_last_issue  = (r_remaining == MEM_BEAT_ADDR_WIDTH'(1));

  // Credits count both buffered beats and the read still in the RAM pipeline
  assign w_used       = USED_W'(r_count) + USED_W'(r_inflight);
  assign w_has_credit = (w_used < USED_W'(OUT_FIFO_DEPTH));

  // Next-state and issue decode
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req_hs) begin
          w_state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        if (w_has_credit) begin
          w_issue = 1'b1;
          if (w_last_issue) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register; ready mirrors the next state so it stays low through reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= (w_state_nxt == ST_IDLE);
    end
  end

  // Burst address/length tracking and RAM pipeline tag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_buf           <= '0;
      r_addr          <= '0;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      if (w_req_hs) begin
        r_buf       <= w_req.buf_idx;
        r_addr      <= w_req.addr[RAM_ADDR_WIDTH-1:0];
        r_remaining <= eff_length(w_req.length);
      end else if (w_issue) begin
        r_addr      <= r_addr + RAM_ADDR_WIDTH'(1);
        r_remaining <= r_remaining - MEM_BEAT_ADDR_WIDTH'(1);
      end
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue & w_last_issue;
    end
  end

  mem_buf_server_ram #(
    .DATA_W (AXI4S_DATA_WIDTH),
    .ADDR_W (RAM_AW)
  ) u_ram (
    .clk       (clk),
    .i_rst_n   (reset),
    .i_wr_en   (wr_en),
    .i_wr_addr ({wr_buf_idx, wr_addr}),
    .i_wr_data (wr_data),
    .i_rd_en   (w_issue),
    .i_rd_addr ({r_buf, r_addr}),
    .o_rd_data (w_ram_rd_data)
  );

  assign w_fifo_nonempty = (r_count != '0);
  assign w_push          = r_inflight;
  assign w_pop           = w_fifo_nonempty & rsp_axis_tready;

  // Output FIFO storage and pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < OUT_FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_last[i] <= 1'b0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= w_ram_rd_data;
        r_fifo_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  // FIFO occupancy; simultaneous push and pop leave it unchanged
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky request error flags and response beat counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err      <= '0;
      r_beat_cnt <= '0;
    end else begin
      if (w_req_hs) begin
        r_err <= r_err | {w_addr_hi_err, (w_req.length == '0)};
      end
      if (w_pop) begin
        r_beat_cnt <= r_beat_cnt + 16'd1;
      end
    end
  end

  assign req_axis_tready = r_req_ready;
  assign rsp_axis_tvalid = w_fifo_nonempty;
  assign rsp_axis_tdata  = r_fifo_data[r_rd_ptr];
  assign rsp_axis_tlast  = r_fifo_last[r_rd_ptr];
  assign busy_out        = (r_state == ST_READ) | r_inflight | w_fifo_nonempty;
  assign err_out         = r_err;
  assign beat_count_out  = r_beat_cnt;

endmodule
